load_store_queue: RTL and testbench

Parametrised successor to the memory functional unit's store buffer. It holds in-flight stores in program order and captures their data from the CDB, and releases them to memory once committed. It checks every load address against older stores: the youngest matching store forwards its data or stalls the load, and a load with no match bypasses straight to memory. It sits between the in-order address-compute stage and the memory port, adds a speculative flush, and reports occupancy.

---
 rtl/load_store_queue.sv | 188 ++++++++++++++++++
 tb/tb_load_store_queue.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_queue.sv
// Load/store queue: in-order store buffer with CDB capture, commit/drain and load disambiguation.
// Store-to-load forwarding is built only when LSQ_FORWARD_EN is defined; otherwise any match stalls the load.
module load_store_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   s_alloc_valid,
  output logic                   s_alloc_ready,
  input  logic [ID_W-1:0]        s_alloc_id,
  input  logic [ID_W-1:0]        s_alloc_data_id,
  input  logic [DATA_W-1:0]      s_alloc_data,
  input  logic                   s_alloc_data_rdy,
  input  logic                   a_valid,
  output logic                   a_ready,
  input  logic                   a_is_store,
  input  logic [ID_W-1:0]        a_id,
  input  logic [ADDR_W-1:0]      a_addr,
  input  logic                   cdb_valid,
  input  logic [ID_W+DATA_W-1:0] cdb,
  input  logic                   commit_valid,
  input  logic [ID_W-1:0]        commit_id,
  input  logic                   flush,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic                   m_write,
  output logic [ID_W-1:0]        m_id,
  output logic [ADDR_W-1:0]      m_addr,
  output logic [DATA_W-1:0]      m_data,
  output logic                   f_valid,
  input  logic                   f_ready,
  output logic [ID_W+DATA_W-1:0] f_cdb,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic              valid;
    logic [ID_W-1:0]   id;
    logic [ID_W-1:0]   data_id;
    logic [DATA_W-1:0] data;
    logic              data_rdy;
    logic [ADDR_W-1:0] addr;
    logic              addr_rdy;
    logic              committed;
  } entry_t;

  entry_t          q [DEPTH];
  entry_t          q_nxt [DEPTH];
  logic [PW-1:0]   head, tail;
  logic [CW-1:0]   n_comm;
  logic [ID_W-1:0] cdb_tag;
  logic [DATA_W-1:0] cdb_data;
  logic hit, any_old, full, is_load, io, ld_req, fwd, dr_req, ld_go, st_go;
  logic alloc_fire, drain_fire, st_addr_fire;
  entry_t hq;
`ifdef LSQ_FORWARD_EN
  logic [PW-1:0] hit_idx;
`endif

  assign cdb_tag  = cdb[ID_W+DATA_W-1:DATA_W];
  assign cdb_data = cdb[DATA_W-1:0];
  assign full     = (count == CW'(DEPTH));
  assign hq       = q[head];

  // Walk oldest to youngest so the last match found is the one nearest tail.
  always_comb begin
    logic [PW-1:0] j;
    hit = 1'b0;
    any_old = 1'b0;
`ifdef LSQ_FORWARD_EN
    hit_idx = '0;
`endif
    for (int k = 0; k < DEPTH; k++) begin
      j = head + PW'(k);
      if (q[j].valid && q[j].addr_rdy) begin
        any_old = 1'b1;
        if (q[j].addr == a_addr) begin
          hit = 1'b1;
`ifdef LSQ_FORWARD_EN
          hit_idx = j;
`endif
        end
      end
    end
  end

  assign is_load = ~rst & a_valid & ~a_is_store & ~flush;
  assign io      = &a_addr;
  assign ld_req  = is_load & (io ? ~any_old : ~hit);
`ifdef LSQ_FORWARD_EN
  assign fwd     = is_load & ~io & hit & q[hit_idx].data_rdy;
  assign f_cdb   = {a_id, q[hit_idx].data};
`else
  assign fwd     = 1'b0;
  assign f_cdb   = '0;
`endif
  assign f_valid = fwd;

  // A full queue lets the drainable head go first so allocation can resume.
  assign dr_req = ~rst & hq.valid & hq.committed & hq.data_rdy & hq.addr_rdy;
  assign ld_go  = ld_req & ~(full & dr_req);
  assign st_go  = dr_req & ~ld_go;

  assign m_valid = ld_go | st_go;
  assign m_write = st_go;
  assign m_id    = st_go ? hq.id   : a_id;
  assign m_addr  = st_go ? hq.addr : a_addr;
  assign m_data  = st_go ? hq.data : '0;

  always_comb begin
    a_ready = 1'b0;
    if (!rst && a_valid) begin
      if (a_is_store)  a_ready = 1'b1;
      else if (ld_go)  a_ready = m_ready;
      else if (fwd)    a_ready = f_ready;
    end
  end

  assign s_alloc_ready = ~rst & ~full & ~flush;
  assign alloc_fire    = s_alloc_valid & s_alloc_ready;
  assign drain_fire    = st_go & m_ready;
  assign st_addr_fire  = ~rst & a_valid & a_is_store;

  // Committed entries surviving this cycle, counting a same-cycle commit.
  always_comb begin
    n_comm = '0;
    for (int i = 0; i < DEPTH; i++)
      if (q[i].valid && (q[i].committed || (commit_valid && q[i].id == commit_id)))
        n_comm = n_comm + CW'(1);
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entry_t e;
      e = q[i];
      if (e.valid && !e.data_rdy && cdb_valid && e.data_id == cdb_tag) begin
        e.data = cdb_data;
        e.data_rdy = 1'b1;
      end
      if (e.valid && st_addr_fire && e.id == a_id) begin
        e.addr = a_addr;
        e.addr_rdy = 1'b1;
      end
      if (e.valid && commit_valid && e.id == commit_id) e.committed = 1'b1;
      if (flush && !e.committed) e = '0;
      if (drain_fire && PW'(i) == head) e = '0;
      if (alloc_fire && PW'(i) == tail) begin
        e.valid     = 1'b1;
        e.id        = s_alloc_id;
        e.data_id   = s_alloc_data_id;
        e.data      = s_alloc_data;
        e.data_rdy  = s_alloc_data_rdy;
        e.addr      = '0;
        e.addr_rdy  = 1'b0;
        e.committed = 1'b0;
        if (!s_alloc_data_rdy && cdb_valid && cdb_tag == s_alloc_data_id) begin
          e.data = cdb_data;
          e.data_rdy = 1'b1;
        end
      end
      q_nxt[i] = e;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) q[i] <= q_nxt[i];
      head <= head + PW'(drain_fire);
      if (flush) begin
        tail  <= head + PW'(n_comm);
        count <= n_comm - CW'(drain_fire);
      end else begin
        tail  <= tail + PW'(alloc_fire);
        count <= count + CW'(alloc_fire) - CW'(drain_fire);
      end
    end
  end
endmodule

// File: tb/tb_load_store_queue.sv
// Directed bench for load_store_queue; expectations follow LSQ_FORWARD_EN when it is defined.
module tb_load_store_queue;
  localparam int DEPTH = 4, AW = 32, DW = 32, IW = 6;

  logic clk = 1'b0;
  logic rst;
  logic s_alloc_valid, s_alloc_ready, s_alloc_data_rdy;
  logic [IW-1:0] s_alloc_id, s_alloc_data_id;
  logic [DW-1:0] s_alloc_data;
  logic a_valid, a_ready, a_is_store;
  logic [IW-1:0] a_id;
  logic [AW-1:0] a_addr;
  logic cdb_valid;
  logic [IW+DW-1:0] cdb;
  logic commit_valid;
  logic [IW-1:0] commit_id;
  logic flush;
  logic m_valid, m_ready, m_write;
  logic [IW-1:0] m_id;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  logic f_valid, f_ready;
  logic [IW+DW-1:0] f_cdb;
  logic [$clog2(DEPTH):0] count;

  int pass_cnt = 0, total_cnt = 0;

  always #5 clk = ~clk;

  load_store_queue #(.DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) dut (
    .clk(clk), .rst(rst),
    .s_alloc_valid(s_alloc_valid), .s_alloc_ready(s_alloc_ready), .s_alloc_id(s_alloc_id),
    .s_alloc_data_id(s_alloc_data_id), .s_alloc_data(s_alloc_data), .s_alloc_data_rdy(s_alloc_data_rdy),
    .a_valid(a_valid), .a_ready(a_ready), .a_is_store(a_is_store), .a_id(a_id), .a_addr(a_addr),
    .cdb_valid(cdb_valid), .cdb(cdb), .commit_valid(commit_valid), .commit_id(commit_id),
    .flush(flush), .m_valid(m_valid), .m_ready(m_ready), .m_write(m_write), .m_id(m_id),
    .m_addr(m_addr), .m_data(m_data), .f_valid(f_valid), .f_ready(f_ready), .f_cdb(f_cdb),
    .count(count)
  );

  task automatic idle();
    s_alloc_valid = 0; s_alloc_id = '0; s_alloc_data_id = '0; s_alloc_data = '0; s_alloc_data_rdy = 0;
    a_valid = 0; a_is_store = 0; a_id = '0; a_addr = '0;
    cdb_valid = 0; cdb = '0; commit_valid = 0; commit_id = '0; flush = 0;
    m_ready = 0; f_ready = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic alloc(input logic [IW-1:0] id, input logic [IW-1:0] did, input logic [DW-1:0] d, input logic rdy);
    s_alloc_valid = 1; s_alloc_id = id; s_alloc_data_id = did; s_alloc_data = d; s_alloc_data_rdy = rdy;
    step();
    s_alloc_valid = 0;
  endtask

  task automatic staddr(input logic [IW-1:0] id, input logic [AW-1:0] addr);
    a_valid = 1; a_is_store = 1; a_id = id; a_addr = addr;
    step();
    a_valid = 0; a_is_store = 0;
  endtask

  task automatic commit(input logic [IW-1:0] id);
    commit_valid = 1; commit_id = id;
    step();
    commit_valid = 0;
  endtask

  task automatic load(input logic [IW-1:0] id, input logic [AW-1:0] addr);
    a_valid = 1; a_is_store = 0; a_id = id; a_addr = addr;
  endtask

  task automatic test_reset();
    idle();
    rst = 1; s_alloc_valid = 1; load(6'd1, 32'h10);
    step(); step();
    total_cnt++; if (s_alloc_ready !== 1'b0) $display("FAIL rst_alloc_ready got %0h exp 0", s_alloc_ready); else pass_cnt++;
    total_cnt++; if (a_ready !== 1'b0) $display("FAIL rst_a_ready got %0h exp 0", a_ready); else pass_cnt++;
    total_cnt++; if (m_valid !== 1'b0) $display("FAIL rst_m_valid got %0h exp 0", m_valid); else pass_cnt++;
    total_cnt++; if (f_valid !== 1'b0) $display("FAIL rst_f_valid got %0h exp 0", f_valid); else pass_cnt++;
    rst = 0; idle(); #1;
    total_cnt++; if (count !== 3'd0) $display("FAIL rst_count got %0d exp 0", count); else pass_cnt++;
    total_cnt++; if (s_alloc_ready !== 1'b1) $display("FAIL post_rst_alloc_ready got %0h exp 1", s_alloc_ready); else pass_cnt++;
  endtask

  task automatic test_drain();
    alloc(6'd3, 6'd0, 32'hAA, 1'b1);
    total_cnt++; if (count !== 3'd1) $display("FAIL drain_count1 got %0d exp 1", count); else pass_cnt++;
    staddr(6'd3, 32'h10);
    commit(6'd3);
    total_cnt++; if ({m_valid, m_write} !== 2'b11) $display("FAIL drain_valid_write got %b exp 11", {m_valid, m_write}); else pass_cnt++;
    total_cnt++; if (m_addr !== 32'h10) $display("FAIL drain_addr got %0h exp 10", m_addr); else pass_cnt++;
    total_cnt++; if (m_data !== 32'hAA) $display("FAIL drain_data got %0h exp aa", m_data); else pass_cnt++;
    total_cnt++; if (m_id !== 6'd3) $display("FAIL drain_id got %0d exp 3", m_id); else pass_cnt++;
    m_ready = 1; step(); m_ready = 0; #1;
    total_cnt++; if (count !== 3'd0) $display("FAIL drain_count0 got %0d exp 0", count); else pass_cnt++;
    total_cnt++; if (m_valid !== 1'b0) $display("FAIL drain_idle got %0h exp 0", m_valid); else pass_cnt++;
  endtask

  task automatic test_forward();
    alloc(6'd1, 6'd0, 32'h11, 1'b1);
    alloc(6'd2, 6'd0, 32'h22, 1'b1);
    staddr(6'd1, 32'h20);
    staddr(6'd2, 32'h20);
    load(6'd5, 32'h20); f_ready = 1; #1;
    total_cnt++; if (m_valid !== 1'b0) $display("FAIL fwd_m_valid got %0h exp 0", m_valid); else pass_cnt++;
`ifdef LSQ_FORWARD_EN
    total_cnt++; if (f_valid !== 1'b1) $display("FAIL fwd_f_valid got %0h exp 1", f_valid); else pass_cnt++;
    total_cnt++; if (f_cdb !== {6'd5, 32'h22}) $display("FAIL fwd_f_cdb got %0h exp %0h", f_cdb, {6'd5, 32'h22}); else pass_cnt++;
    total_cnt++; if (a_ready !== 1'b1) $display("FAIL fwd_a_ready got %0h exp 1", a_ready); else pass_cnt++;
`else
    total_cnt++; if (f_valid !== 1'b0) $display("FAIL fwd_f_valid got %0h exp 0", f_valid); else pass_cnt++;
    total_cnt++; if (a_ready !== 1'b0) $display("FAIL fwd_a_ready got %0h exp 0", a_ready); else pass_cnt++;
`endif
    step();
    a_valid = 0; f_ready = 0; flush = 1;
    step();
    flush = 0; #1;
    total_cnt++; if (count !== 3'd0) $display("FAIL fwd_flush_count got %0d exp 0", count); else pass_cnt++;
  endtask

  task automatic test_stall_cdb();
    alloc(6'd1, 6'd9, 32'h0, 1'b0);
    staddr(6'd1, 32'h30);
    load(6'd6, 32'h30); f_ready = 1; m_ready = 1; #1;
    total_cnt++; if (a_ready !== 1'b0) $display("FAIL stall_a_ready got %0h exp 0", a_ready); else pass_cnt++;
    total_cnt++; if (m_valid !== 1'b0) $display("FAIL stall_m_valid got %0h exp 0", m_valid); else pass_cnt++;
    cdb_valid = 1; cdb = {6'd9, 32'h77};
    step();
    cdb_valid = 0; #1;
`ifdef LSQ_FORWARD_EN
    total_cnt++; if (f_valid !== 1'b1) $display("FAIL cdb_f_valid got %0h exp 1", f_valid); else pass_cnt++;
    total_cnt++; if (f_cdb !== {6'd6, 32'h77}) $display("FAIL cdb_f_cdb got %0h exp %0h", f_cdb, {6'd6, 32'h77}); else pass_cnt++;
`else
    total_cnt++; if ({f_valid, a_ready} !== 2'b00) $display("FAIL cdb_nofwd_stall got %b exp 00", {f_valid, a_ready}); else pass_cnt++;
`endif
    f_ready = 0;
    commit(6'd1);
    total_cnt++; if ({m_valid, m_write, a_ready} !== 3'b110) $display("FAIL cdb_drain_hs got %b exp 110", {m_valid, m_write, a_ready}); else pass_cnt++;
    total_cnt++; if (m_data !== 32'h77) $display("FAIL cdb_drain_data got %0h exp 77", m_data); else pass_cnt++;
    step();
    total_cnt++; if ({m_valid, m_write, a_ready} !== 3'b101) $display("FAIL cdb_bypass_hs got %b exp 101", {m_valid, m_write, a_ready}); else pass_cnt++;
    total_cnt++; if ({m_id, m_addr} !== {6'd6, 32'h30}) $display("FAIL cdb_bypass_req got %0h exp %0h", {m_id, m_addr}, {6'd6, 32'h30}); else pass_cnt++;
    step();
    a_valid = 0; m_ready = 0; #1;
    total_cnt++; if (count !== 3'd0) $display("FAIL cdb_count got %0d exp 0", count); else pass_cnt++;
  endtask

  task automatic test_flush();
    for (int k = 1; k <= 4; k++) alloc(IW'(k), 6'd0, DW'(k * 16), 1'b1);
    total_cnt++; if (count !== 3'd4) $display("FAIL flush_full_count got %0d exp 4", count); else pass_cnt++;
    total_cnt++; if (s_alloc_ready !== 1'b0) $display("FAIL flush_full_ready got %0h exp 0", s_alloc_ready); else pass_cnt++;
    commit(6'd1);
    commit(6'd2);
    flush = 1; load(6'd10, 32'h50); m_ready = 1; #1;
    total_cnt++; if ({a_ready, m_valid} !== 2'b00) $display("FAIL flush_load_blocked got %b exp 00", {a_ready, m_valid}); else pass_cnt++;
    step();
    flush = 0; a_valid = 0; m_ready = 0; #1;
    total_cnt++; if (count !== 3'd2) $display("FAIL flush_count got %0d exp 2", count); else pass_cnt++;
    alloc(6'd7, 6'd0, 32'h70, 1'b1);
    total_cnt++; if (count !== 3'd3) $display("FAIL flush_alloc_count got %0d exp 3", count); else pass_cnt++;
    staddr(6'd1, 32'h61);
    staddr(6'd2, 32'h62);
    staddr(6'd7, 32'h60);
    commit(6'd7);
    total_cnt++; if ({m_id, m_addr} !== {6'd1, 32'h61}) $display("FAIL flush_drain1 got %0h exp %0h", {m_id, m_addr}, {6'd1, 32'h61}); else pass_cnt++;
    m_ready = 1; step();
    total_cnt++; if ({m_id, m_addr} !== {6'd2, 32'h62}) $display("FAIL flush_drain2 got %0h exp %0h", {m_id, m_addr}, {6'd2, 32'h62}); else pass_cnt++;
    step();
    total_cnt++; if ({m_id, m_addr, m_data} !== {6'd7, 32'h60, 32'h70}) $display("FAIL flush_drain3 got %0h exp %0h", {m_id, m_addr, m_data}, {6'd7, 32'h60, 32'h70}); else pass_cnt++;
    step();
    m_ready = 0; #1;
    total_cnt++; if ({count, m_valid} !== 4'b0000) $display("FAIL flush_empty got %b exp 0000", {count, m_valid}); else pass_cnt++;
  endtask

  task automatic test_full_arb();
    for (int k = 1; k <= 4; k++) alloc(IW'(k), 6'd0, DW'(32'hA0 + k), 1'b1);
    for (int k = 1; k <= 4; k++) staddr(IW'(k), AW'(32'h80 + k));
    commit(6'd1);
    load(6'd8, 32'h40); m_ready = 1; #1;
    total_cnt++; if ({m_valid, m_write, a_ready} !== 3'b110) $display("FAIL full_store_first got %b exp 110", {m_valid, m_write, a_ready}); else pass_cnt++;
    total_cnt++; if (m_addr !== 32'h81) $display("FAIL full_store_addr got %0h exp 81", m_addr); else pass_cnt++;
    step();
    total_cnt++; if ({m_valid, m_write, a_ready} !== 3'b101) $display("FAIL full_load_next got %b exp 101", {m_valid, m_write, a_ready}); else pass_cnt++;
    total_cnt++; if ({m_id, m_addr, count} !== {6'd8, 32'h40, 3'd3}) $display("FAIL full_load_req got %0h exp %0h", {m_id, m_addr, count}, {6'd8, 32'h40, 3'd3}); else pass_cnt++;
    step();
    a_valid = 0; m_ready = 0; flush = 1;
    step();
    flush = 0; #1;
    total_cnt++; if (count !== 3'd0) $display("FAIL full_flush_count got %0d exp 0", count); else pass_cnt++;
  endtask

  task automatic test_io();
    alloc(6'd1, 6'd0, 32'h55, 1'b1);
    staddr(6'd1, 32'h90);
    load(6'd9, 32'hFFFF_FFFF); m_ready = 1; #1;
    total_cnt++; if ({a_ready, m_valid} !== 2'b00) $display("FAIL io_stall got %b exp 00", {a_ready, m_valid}); else pass_cnt++;
    commit(6'd1);
    total_cnt++; if ({m_valid, m_write, a_ready} !== 3'b110) $display("FAIL io_drain_hs got %b exp 110", {m_valid, m_write, a_ready}); else pass_cnt++;
    total_cnt++; if (m_addr !== 32'h90) $display("FAIL io_drain_addr got %0h exp 90", m_addr); else pass_cnt++;
    step();
    total_cnt++; if ({m_valid, m_write, a_ready} !== 3'b101) $display("FAIL io_issue_hs got %b exp 101", {m_valid, m_write, a_ready}); else pass_cnt++;
    total_cnt++; if ({m_addr, m_data} !== {32'hFFFF_FFFF, 32'h0}) $display("FAIL io_issue_req got %0h exp ffffffff00000000", {m_addr, m_data}); else pass_cnt++;
    step();
    idle();
  endtask

  initial begin
    test_reset();
    test_drain();
    test_forward();
    test_stall_cdb();
    test_flush();
    test_full_arb();
    test_io();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
